// File: rtl/seq_det_stream_ctrl_pkg.sv
// Shared state encoding and default sizing for the 101-detector stream controller.
package seq_det_pkg;

  localparam int WIDTH_DEF     = 15;
  localparam int LEN_W_DEF     = 4;
  localparam int CNT_W_DEF     = 4;
  localparam int DRAIN_CYC_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/seq_det_stream_ctrl_if.sv
// Control/stream bundle between a harness (master) and the stream controller (slave).
interface seq_det_stream_ctrl_if
  import seq_det_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int LEN_W = LEN_W_DEF,
  parameter int CNT_W = CNT_W_DEF
);

  logic             start;
  logic             abort;
  logic [WIDTH-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic             x_out;
  logic             det_in;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] det_count;
  logic             det_sat;

  modport master (
    output start, abort, pattern, len, det_in,
    input  x_out, busy, done, det_count, det_sat
  );

  modport slave (
    input  start, abort, pattern, len, det_in,
    output x_out, busy, done, det_count, det_sat
  );

endinterface

// File: rtl/seq_det_stream_ctrl_sat_counter.sv
// Clearable, enable-driven up counter that sticks at all-ones and flags the overflow attempt.
module sat_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count,
  output logic             o_sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_count;
  logic             r_sat;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_sat   <= 1'b0;
    end else if (i_clr) begin
      r_count <= '0;
      r_sat   <= 1'b0;
    end else if (i_inc) begin
      if (r_count == CNT_MAX) r_sat   <= 1'b1;
      else                    r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;
  assign o_sat   = r_sat;

endmodule

// File: rtl/seq_det_stream_ctrl.sv
// Serialises a pattern word MSB-first onto the detector x input and counts y pulses,
// including a drain window so a registered (Moore) detector output is not lost.
module seq_det_stream_ctrl
  import seq_det_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int LEN_W     = LEN_W_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int DRAIN_CYC = DRAIN_CYC_DEF
) (
  input logic                clk,
  input logic                rst,
  seq_det_stream_ctrl_if.slave bus
);

  localparam int               DW         = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam int               DRAIN_INIT = (DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0;
  localparam logic [LEN_W-1:0] WIDTH_L    = LEN_W'(WIDTH);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_shift;
  logic [LEN_W-1:0] r_remaining;
  logic [DW-1:0]    r_drain;
  logic             r_x_out;
  logic [LEN_W-1:0] w_len_eff;
  logic             w_accept;
  logic             w_count_en;

  assign w_len_eff  = (bus.len > WIDTH_L) ? WIDTH_L : bus.len;
  assign w_accept   = (r_state == ST_IDLE) && bus.start;
  assign w_count_en = ((r_state == ST_SHIFT) || (r_state == ST_DRAIN)) && bus.det_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // NOTE: the default assignment first keeps every path assigned, so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.start) w_state_next = (bus.len != '0) ? ST_SHIFT : ST_DONE;
      end
      ST_SHIFT: begin
        if (bus.abort)                w_state_next = ST_IDLE;
        else if (r_remaining == '0)   w_state_next = (DRAIN_CYC == 0) ? ST_DONE : ST_DRAIN;
      end
      ST_DRAIN: begin
        if (bus.abort)                w_state_next = ST_IDLE;
        else if (r_drain == '0)       w_state_next = ST_DONE;
      end
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // r_shift holds the bits still to send, already aligned so its MSB is the next x_out bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift     <= '0;
      r_remaining <= '0;
      r_drain     <= '0;
      r_x_out     <= 1'b0;
    end else begin
      r_x_out <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (bus.start && (bus.len != '0)) begin
            r_shift     <= {bus.pattern[WIDTH-2:0], 1'b0};
            r_x_out     <= bus.pattern[WIDTH-1];
            r_remaining <= w_len_eff - LEN_W'(1);
          end
        end
        ST_SHIFT: begin
          if (!bus.abort) begin
            if (r_remaining == '0) begin
              r_drain <= DW'(DRAIN_INIT);
            end else begin
              r_x_out     <= r_shift[WIDTH-1];
              r_shift     <= {r_shift[WIDTH-2:0], 1'b0};
              r_remaining <= r_remaining - LEN_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (!bus.abort && (r_drain != '0)) r_drain <= r_drain - DW'(1);
        end
        default: ;
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_det_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_accept),
    .i_inc   (w_count_en),
    .o_count (bus.det_count),
    .o_sat   (bus.det_sat)
  );

  assign bus.x_out = r_x_out;
  assign bus.busy  = (r_state == ST_SHIFT) || (r_state == ST_DRAIN);
  assign bus.done  = (r_state == ST_DONE);

endmodule

// File: tb/tb_seq_det_stream_ctrl.sv
// Scoreboard bench: runs push expected x_out bits and done results; a negedge monitor pops and compares.
module tb_seq_det_stream_ctrl;

  localparam int WIDTH     = 15;
  localparam int LEN_W     = 5;
  localparam int CNT_W     = 4;
  localparam int DRAIN_CYC = 2;

  localparam logic [WIDTH-1:0] PAT_MAIN = 15'b011_1010_0101_0100;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  seq_det_stream_ctrl_if #(.WIDTH(WIDTH), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus_if ();

  seq_det_stream_ctrl #(
    .WIDTH(WIDTH), .LEN_W(LEN_W), .CNT_W(CNT_W), .DRAIN_CYC(DRAIN_CYC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic             sat;
  } done_exp_t;

  int        checks = 0;
  int        errors = 0;
  logic      exp_x[$];
  done_exp_t exp_done[$];

  // Stand-in 101 detectors: 0 = manual det_in, 1 = Mealy, 2 = Moore (one cycle later).
  int         det_mode = 0;
  logic       det_manual = 1'b0;
  logic [1:0] m_st;
  logic       mealy_y;
  logic       moore_y;

  assign mealy_y = (m_st == 2'd2) && bus_if.x_out;
  assign bus_if.det_in = (det_mode == 1) ? mealy_y : (det_mode == 2) ? moore_y : det_manual;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_st    <= 2'd0;
      moore_y <= 1'b0;
    end else begin
      moore_y <= mealy_y;
      case (m_st)
        2'd0:    m_st <= bus_if.x_out ? 2'd1 : 2'd0;
        2'd1:    m_st <= bus_if.x_out ? 2'd1 : 2'd2;
        default: m_st <= bus_if.x_out ? 2'd1 : 2'd0;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (bus_if.busy === 1'b1) begin
        if (exp_x.size() == 0) check("busy_unexpected", 32'(bus_if.busy), 32'd0);
        else                   check("x_out", 32'(bus_if.x_out), 32'(exp_x.pop_front()));
      end else if (bus_if.busy === 1'b0) begin
        check("x_out_idle", 32'(bus_if.x_out), 32'd0);
      end
      if (bus_if.done === 1'b1) begin
        if (exp_done.size() == 0) begin
          check("done_unexpected", 32'(bus_if.done), 32'd0);
        end else begin
          done_exp_t d;
          d = exp_done.pop_front();
          check("det_count", 32'(bus_if.det_count), 32'(d.cnt));
          check("det_sat", 32'(bus_if.det_sat), 32'(d.sat));
          check("busy_at_done", 32'(bus_if.busy), 32'd0);
        end
      end
    end
  end

  // One run, entered and left at posedge+1. Cycle k is the cycle after start-sampling edge N+k-1.
  task automatic run(input logic [WIDTH-1:0] pat, input logic [LEN_W-1:0] ln, input int mode,
                     input logic det_val, input int det_off_at, input int restart_at,
                     input int abort_at, input logic abort_with_start,
                     input int exp_cnt, input logic exp_sat);
    int        l;
    int        lat;
    done_exp_t d;
    l = (int'(ln) > WIDTH) ? WIDTH : int'(ln);
    if (abort_at > 0) begin
      for (int i = 0; i < abort_at; i++) exp_x.push_back(pat[WIDTH-1-i]);
    end else begin
      for (int i = 0; i < l; i++) exp_x.push_back(pat[WIDTH-1-i]);
      if (l > 0) for (int i = 0; i < DRAIN_CYC; i++) exp_x.push_back(1'b0);
      d.cnt = CNT_W'(exp_cnt);
      d.sat = exp_sat;
      exp_done.push_back(d);
    end
    det_mode       = mode;
    det_manual     = det_val;
    bus_if.start   = 1'b1;
    bus_if.pattern = pat;
    bus_if.len     = ln;
    bus_if.abort   = abort_with_start;
    @(posedge clk); #1;
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      bus_if.start   = (k == restart_at);
      bus_if.pattern = (k == restart_at) ? ~pat : pat;
      bus_if.len     = (k == restart_at) ? LEN_W'(3) : ln;
      bus_if.abort   = (k == abort_at);
      if (k == det_off_at) det_manual = 1'b0;
      @(negedge clk);
      if (abort_at > 0 && k == abort_at + 1) begin
        check("abort_busy", 32'(bus_if.busy), 32'd0);
        check("abort_done", 32'(bus_if.done), 32'd0);
        check("abort_count", 32'(bus_if.det_count), 32'(exp_cnt));
        check("abort_sat", 32'(bus_if.det_sat), 32'(exp_sat));
        lat = k;
        break;
      end
      if (bus_if.done === 1'b1) begin
        lat = k;
        break;
      end
      @(posedge clk); #1;
    end
    if (abort_at == 0) check("done_latency", 32'(lat), 32'((l == 0) ? 1 : l + DRAIN_CYC + 1));
    else               check("abort_reached", 32'(lat), 32'(abort_at + 1));
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    bus_if.abort = 1'b0;
    det_manual   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("bits_left", 32'(exp_x.size()), 32'd0);
    check("done_left", 32'(exp_done.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.start   = 1'b0;
    bus_if.abort   = 1'b0;
    bus_if.pattern = '0;
    bus_if.len     = '0;
    #3 rst = 1'b1;
    #1;
    check("rst_x_out", 32'(bus_if.x_out), 32'd0);
    check("rst_busy", 32'(bus_if.busy), 32'd0);
    check("rst_done", 32'(bus_if.done), 32'd0);
    check("rst_count", 32'(bus_if.det_count), 32'd0);
    check("rst_sat", 32'(bus_if.det_sat), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // pat, len, mode, det_val, det_off_at, restart_at, abort_at, abort_with_start, cnt, sat
    run(PAT_MAIN, 5'd15, 0, 1'b0, 0, 3, 0, 1'b0, 0, 1'b0);   // plain serialisation, restart ignored
    run(PAT_MAIN, 5'd15, 1, 1'b0, 0, 0, 0, 1'b0, 3, 1'b0);   // Mealy detector: 3 hits
    run(PAT_MAIN, 5'd15, 2, 1'b0, 0, 0, 0, 1'b0, 3, 1'b0);   // Moore detector: 3 hits
    run(15'h7FFF, 5'd0, 0, 1'b1, 0, 0, 0, 1'b0, 0, 1'b0);    // len 0: done next cycle, det ignored
    run(15'h5A3C, 5'd20, 0, 1'b0, 0, 0, 0, 1'b1, 0, 1'b0);   // clamped to 15, abort with start ignored
    run(15'h2AAA, 5'd15, 0, 1'b1, 0, 18, 0, 1'b0, 15, 1'b1); // saturation, start during DONE ignored
    run(15'h6B5D, 5'd15, 0, 1'b1, 4, 0, 5, 1'b0, 3, 1'b0);   // abort during 5th bit, partial count 3
    run(15'h5000, 5'd3, 2, 1'b0, 0, 0, 0, 1'b0, 1, 1'b0);    // Moore hit lands in DRAIN

    // Asynchronous reset in the middle of a run, two bits into it.
    exp_x.push_back(PAT_MAIN[WIDTH-1]);
    exp_x.push_back(PAT_MAIN[WIDTH-2]);
    det_mode       = 0;
    det_manual     = 1'b1;
    bus_if.start   = 1'b1;
    bus_if.pattern = PAT_MAIN;
    bus_if.len     = 5'd15;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_x_out", 32'(bus_if.x_out), 32'd0);
    check("midrst_busy", 32'(bus_if.busy), 32'd0);
    check("midrst_done", 32'(bus_if.done), 32'd0);
    check("midrst_count", 32'(bus_if.det_count), 32'd0);
    check("midrst_sat", 32'(bus_if.det_sat), 32'd0);
    check("midrst_bits_left", 32'(exp_x.size()), 32'd0);
    det_manual = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("final_busy", 32'(bus_if.busy), 32'd0);
    check("final_done_left", 32'(exp_done.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
